// File: rtl/seven_seg_capture.sv
// Recovers per-digit hex values from a multiplexed active-low seven-segment bus.
// Optional macro SEG_CAPTURE_ERR_EN: record illegal segment patterns in err[].
module seven_seg_capture #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     valid,
    output logic [DIGITS-1:0]     err,
    output logic                  upd,
    output logic [2:0]            upd_idx
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_DONE} state_t;

    logic [6:0]        r_seg_m, r_seg_s, r_seg_p;
    logic [DIGITS-1:0] r_an_m, r_an_s, r_an_p;
    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              w_cap, w_chg, w_sel;
    logic [4:0]        w_dec;
    logic              w_blank;
    logic [2:0]        w_idx;
    logic [3:0]        w_cur_dig, w_new_dig;
    logic              w_cur_v, w_new_v, w_cur_e, w_new_e, w_apply, w_upd;
    logic [4*DIGITS-1:0] r_digits;
    logic [DIGITS-1:0] r_valid;
    logic              r_upd;
    logic [2:0]        r_upd_idx;

    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b0000001: return 5'h10;
            7'b1001111: return 5'h11;
            7'b0010010: return 5'h12;
            7'b0000110: return 5'h13;
            7'b1001100: return 5'h14;
            7'b0100100: return 5'h15;
            7'b0100000: return 5'h16;
            7'b0001111: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0000100: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b1100000: return 5'h1B;
            7'b0110001: return 5'h1C;
            7'b1000010: return 5'h1D;
            7'b0110000: return 5'h1E;
            7'b0111000: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    // Synchronizers plus previous-sample register; all-ones is the idle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_m <= '1; r_seg_s <= '1; r_seg_p <= '1;
            r_an_m  <= '1; r_an_s  <= '1; r_an_p  <= '1;
        end else begin
            r_seg_m <= seg;     r_seg_s <= r_seg_m; r_seg_p <= r_seg_s;
            r_an_m  <= an;      r_an_s  <= r_an_m;  r_an_p  <= r_an_s;
        end
    end

    assign w_chg = (r_seg_s != r_seg_p) || (r_an_s != r_an_p);
    assign w_sel = $onehot(~r_an_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_sel) begin
                    w_state_nxt = S_TRACK;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            S_TRACK: begin
                if (!w_sel) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_chg) begin
                    w_cnt_nxt = CW'(1);
                end else if (r_cnt != CW'(STABLE_CYCLES)) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (!w_sel) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_chg) begin
                    w_state_nxt = S_TRACK;
                    w_cnt_nxt   = CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // Capture on the edge the count reaches the threshold, then park in DONE.
        w_cap = (w_state_nxt == S_TRACK) && (w_cnt_nxt == CW'(STABLE_CYCLES));
        if (w_cap) w_state_nxt = S_DONE;
    end

    assign w_dec   = seg_decode(r_seg_s);
    assign w_blank = (r_seg_s == 7'h7F);

    always_comb begin
        w_idx     = '0;
        w_cur_dig = '0;
        w_cur_v   = 1'b0;
        w_cur_e   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!r_an_s[i]) begin
                w_idx     = 3'(i);
                w_cur_dig = r_digits[4*i +: 4];
                w_cur_v   = r_valid[i];
`ifdef SEG_CAPTURE_ERR_EN
                w_cur_e   = err[i];
`endif
            end
        end
    end

    always_comb begin
        w_new_dig = w_cur_dig;
        w_new_v   = w_cur_v;
        w_new_e   = w_cur_e;
        w_apply   = 1'b0;
        if (w_dec[4]) begin
            w_new_dig = w_dec[3:0];
            w_new_v   = 1'b1;
            w_new_e   = 1'b0;
            w_apply   = 1'b1;
        end else if (w_blank) begin
            w_new_v = 1'b0;
            w_new_e = 1'b0;
            w_apply = 1'b1;
        end else begin
`ifdef SEG_CAPTURE_ERR_EN
            w_new_v = 1'b0;
            w_new_e = 1'b1;
            w_apply = 1'b1;
`endif
        end
        w_upd = w_cap && w_apply &&
                ({w_new_dig, w_new_v, w_new_e} != {w_cur_dig, w_cur_v, w_cur_e});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits  <= '0;
            r_valid   <= '0;
            r_upd     <= 1'b0;
            r_upd_idx <= '0;
        end else begin
            r_upd <= w_upd;
            if (w_upd) begin
                r_upd_idx <= w_idx;
                for (int i = 0; i < DIGITS; i++) begin
                    if (!r_an_s[i]) begin
                        r_digits[4*i +: 4] <= w_new_dig;
                        r_valid[i]         <= w_new_v;
                    end
                end
            end
        end
    end

`ifdef SEG_CAPTURE_ERR_EN
    logic [DIGITS-1:0] r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else if (w_upd) begin
            for (int i = 0; i < DIGITS; i++)
                if (!r_an_s[i]) r_err[i] <= w_new_e;
        end
    end
    assign err = r_err;
`else
    assign err = '0;
`endif

    assign digits  = r_digits;
    assign valid   = r_valid;
    assign upd     = r_upd;
    assign upd_idx = r_upd_idx;
endmodule
